// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bus bundle between the MIPS core requesters, the RAM and mem_arbiter.
//
// Signal groups:
//   fetch port : iREN, iaddr (core -> arb), iwait, iload (arb -> core)
//   data port  : dREN, dWEN, daddr, dstore (core -> arb), dwait, dload (arb -> core)
//   RAM port   : ramREN, ramWEN, ramaddr, ramstore (arb -> RAM), ramload, ramstate (RAM -> arb)
//   status     : merr (arb -> system), one-cycle pulse on RAM ERROR
//
// Modports:
//   slave  : the arbiter's view (takes core requests, drives the RAM)
//   master : the environment's view (core requesters plus the RAM)
interface mem_arbiter_if #(
  parameter int unsigned AW = 32
);
  logic          iREN;
  logic [AW-1:0] iaddr;
  logic          iwait;
  logic [AW-1:0] iload;

  logic          dREN;
  logic          dWEN;
  logic [AW-1:0] daddr;
  logic [AW-1:0] dstore;
  logic          dwait;
  logic [AW-1:0] dload;

  logic          ramREN;
  logic          ramWEN;
  logic [AW-1:0] ramaddr;
  logic [AW-1:0] ramstore;
  logic [AW-1:0] ramload;
  logic [1:0]    ramstate;

  logic          merr;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, merr
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, merr
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single-ported unified RAM between instruction fetch and the
// data (load/store) port of the pipelined MIPS core.
//
// Data requests win arbitration, except that after STARVE_LIMIT consecutive data grants
// taken while a fetch was pending, the fetch is forced through. STARVE_LIMIT = 0 gives
// pure data priority. Every transaction is followed by one IDLE turnaround cycle.
//
// Ports:
//   CLK   : system clock, rising edge
//   nRST  : asynchronous active-low reset
//   bus   : mem_arbiter_if.slave (fetch port, data port, RAM port, merr)
//   icnt, dcnt, istall : performance counters, present only when ARB_PERF_CNT_EN is defined
//
// Optional feature macro: ARB_PERF_CNT_EN
//   icnt   - completed fetch transactions (RAM ERROR excluded)
//   dcnt   - completed data transactions (RAM ERROR excluded)
//   istall - cycles with iREN=1 and iwait=1
//   All 32 bits, wrapping.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned AW           = 32
) (
  input  logic         CLK,
  input  logic         nRST,
  mem_arbiter_if.slave bus
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]  icnt,
  output logic [31:0]  dcnt,
  output logic [31:0]  istall
`endif
);

  // RAM state encoding
  localparam logic [1:0] RamFree   = 2'd0;
  localparam logic [1:0] RamBusy   = 2'd1;
  localparam logic [1:0] RamAccess = 2'd2;
  localparam logic [1:0] RamError  = 2'd3;

  // Arbiter FSM states
  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StIgnt = 2'd1;
  localparam logic [1:0] StDgnt = 2'd2;

  // Counter only has to reach STARVE_LIMIT, where it saturates.
  localparam int unsigned CW = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] StarveMax = CW'(STARVE_LIMIT);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] starve_cnt_q, starve_cnt_d;

  logic          starved;
  logic          d_req;

  logic          ram_ren;
  logic          ram_wen;
  logic [AW-1:0] ram_addr;
  logic [AW-1:0] ram_store;
  logic          i_wait;
  logic          d_wait;
  logic [AW-1:0] i_load;
  logic [AW-1:0] d_load;
  logic          m_err;
  logic          i_done;
  logic          d_done;

  assign d_req   = bus.dREN | bus.dWEN;
  assign starved = (STARVE_LIMIT != 0) && bus.iREN && (starve_cnt_q == StarveMax);

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    ram_ren      = 1'b0;
    ram_wen      = 1'b0;
    ram_addr     = '0;
    ram_store    = '0;
    i_wait       = 1'b1;
    d_wait       = 1'b1;
    i_load       = '0;
    d_load       = '0;
    m_err        = 1'b0;
    i_done       = 1'b0;
    d_done       = 1'b0;

    case (state_q)
      StIdle: begin
        if (d_req && !starved) begin
          state_d = StDgnt;
          if (bus.iREN && (starve_cnt_q != StarveMax)) begin
            starve_cnt_d = starve_cnt_q + CW'(1);
          end
        end else if (bus.iREN) begin
          state_d      = StIgnt;
          starve_cnt_d = '0;
        end
        // No fetch waiting means nothing is being starved.
        if (!bus.iREN) begin
          starve_cnt_d = '0;
        end
      end

      StIgnt: begin
        ram_addr = bus.iaddr;
        if (!bus.iREN) begin
          // Fetch squashed: drop the RAM request, no completion pulse.
          state_d = StIdle;
        end else begin
          ram_ren = 1'b1;
          case (bus.ramstate)
            RamAccess: begin
              i_wait  = 1'b0;
              i_load  = bus.ramload;
              i_done  = 1'b1;
              state_d = StIdle;
            end
            RamError: begin
              i_wait  = 1'b0;
              m_err   = 1'b1;
              state_d = StIdle;
            end
            default: ;
          endcase
        end
      end

      StDgnt: begin
        ram_addr  = bus.daddr;
        ram_store = bus.dstore;
        if (!d_req) begin
          state_d = StIdle;
        end else begin
          // Write wins when both enables are asserted.
          if (bus.dWEN) begin
            ram_wen = 1'b1;
          end else begin
            ram_ren = 1'b1;
          end
          case (bus.ramstate)
            RamAccess: begin
              d_wait  = 1'b0;
              d_load  = bus.ramload;
              d_done  = 1'b1;
              state_d = StIdle;
            end
            RamError: begin
              d_wait  = 1'b0;
              m_err   = 1'b1;
              state_d = StIdle;
            end
            default: ;
          endcase
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= StIdle;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign bus.ramREN   = ram_ren;
  assign bus.ramWEN   = ram_wen;
  assign bus.ramaddr  = ram_addr;
  assign bus.ramstore = ram_store;
  assign bus.iwait    = i_wait;
  assign bus.iload    = i_load;
  assign bus.dwait    = d_wait;
  assign bus.dload    = d_load;
  assign bus.merr     = m_err;

`ifdef ARB_PERF_CNT_EN
  logic [31:0] icnt_q, icnt_d;
  logic [31:0] dcnt_q, dcnt_d;
  logic [31:0] istall_q, istall_d;

  always_comb begin
    icnt_d   = icnt_q;
    dcnt_d   = dcnt_q;
    istall_d = istall_q;
    if (i_done) begin
      icnt_d = icnt_q + 32'd1;
    end
    if (d_done) begin
      dcnt_d = dcnt_q + 32'd1;
    end
    if (bus.iREN && i_wait) begin
      istall_d = istall_q + 32'd1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      icnt_q   <= '0;
      dcnt_q   <= '0;
      istall_q <= '0;
    end else begin
      icnt_q   <= icnt_d;
      dcnt_q   <= dcnt_d;
      istall_q <= istall_d;
    end
  end

  assign icnt   = icnt_q;
  assign dcnt   = dcnt_q;
  assign istall = istall_q;
`else
  // Completion strobes only feed the performance counters.
  logic unused_done;
  assign unused_done = i_done ^ d_done;
`endif

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequential arbiter sharing the single-ported unified RAM between the instruction-fetch port and the data (load/store) port of the pipelined MIPS core.
- Sits between the fetch/MEM stages and RAM. Its iwait and dwait outputs are the stall sources the pipeline stall/flush logic consumes.
- Data requests have priority. A starvation guard bounds how long instruction fetch can be locked out.

Parameters:
- STARVE_LIMIT, 4, consecutive data grants with iREN pending before fetch is forced to win; 0 disables the guard (pure data priority).
- AW, 32, address/data width (word_t).

Ports:
- CLK  in  1  system clock, rising edge
- nRST  in  1  asynchronous active-low reset
- iREN  in  1  instruction read request
- iaddr  in  AW  instruction address
- iwait  out  1  high = fetch not complete
- iload  out  AW  fetched instruction
- dREN  in  1  data read request
- dWEN  in  1  data write request
- daddr  in  AW  data address
- dstore  in  AW  store data
- dwait  out  1  high = data access not complete
- dload  out  AW  load data
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  AW  RAM address
- ramstore  out  AW  RAM write data
- ramload  in  AW  RAM read data
- ramstate  in  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3
- merr  out  1  one-cycle pulse on RAM ERROR

Behaviour:
- Clock and reset: one clock, CLK. Reset is nRST, asynchronous, active-low.
- Reset values: state=IDLE, starve_cnt=0, iwait=1, dwait=1, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, iload=0, dload=0, merr=0.
- FSM states: IDLE, IGNT, DGNT.
- IDLE: no RAM enables; waits held high. Arbitrate on registered state:
  - dREN|dWEN and not starved -> DGNT.
  - else iREN -> IGNT.
  - else stay in IDLE.
  - starved = (STARVE_LIMIT!=0) && iREN && starve_cnt==STARVE_LIMIT.
- Starvation counter: starve_cnt increments (saturating) on each IDLE->DGNT while iREN=1. It clears on IDLE->IGNT, or when iREN=0 in IDLE.
- DGNT: ramaddr=daddr, ramstore=dstore. dWEN=1 -> ramWEN=1, ramREN=0 (write wins if both asserted). Else ramREN=1.
- IGNT: ramaddr=iaddr, ramREN=1, ramWEN=0, ramstore=0.
- Completion: while granted and ramstate==ACCESS:
  - the granted port's wait=0 for that cycle only;
  - its load = ramload (combinational pass-through);
  - the other port's wait stays 1 and its load stays 0.
  - Next state is IDLE (one mandatory turnaround cycle).
- BUSY or FREE while granted: hold state; wait=1.
- ERROR while granted: merr=1 for that cycle; granted wait=0, load=0; next state IDLE.
- Requester drops its request while granted (e.g. fetch squashed by a jump flush): RAM enables deassert combinationally; no wait pulse; next state IDLE.
- Grant is never preempted mid-transaction. A data request arriving during IGNT waits for IDLE.
- Latency: request seen in IDLE at cycle n -> RAM enable at n+1 -> wait=0 in the first cycle with ACCESS (>= n+1). Minimum transaction is 2 cycles including IDLE.
- Requesters must hold address/data stable until wait=0.
- nRST asserted mid-transaction: immediate return to reset values. The RAM request is abandoned; no completion pulse.

Optional Feature:
- ARB_PERF_CNT_EN defined: adds outputs icnt, dcnt, istall (32 bits each, reset 0).
  - icnt/dcnt increment on each completed I/D transaction (ERROR excluded).
  - istall increments each cycle iREN=1 and iwait=1.
  - Counters wrap at 2^32.
- ARB_PERF_CNT_EN undefined: these ports and registers do not exist; behaviour is otherwise identical.

Test Plan:
- Single fetch, RAM latency 0: iREN=1, iaddr=0x40, ramload=0x8C220004 -> ramREN=1, ramaddr=0x40 at cycle 1; iwait=0, iload=0x8C220004 at cycle 1; IDLE at cycle 2.
- Simultaneous iREN and dWEN (daddr=0x100, dstore=0xDEADBEEF, latency 2) -> DGNT first: ramWEN=1, dwait=0 at cycle 3. IGNT follows from cycle 5; iwait=1 throughout DGNT.
- Starvation, STARVE_LIMIT=2: iREN held while dREN is re-asserted every transaction -> two data grants, then the third arbitration goes to IGNT despite dREN=1; starve_cnt returns to 0.
- Abort: iREN deasserted in IGNT while ramstate=BUSY -> ramREN=0 same cycle, iwait stays 1, IDLE next cycle; a pending dREN is then granted.
- ERROR: ramstate=3 during DGNT (read of 0x200) -> merr=1 for one cycle, dwait=0, dload=0; then IDLE. With ARB_PERF_CNT_EN, dcnt is unchanged.
- Reset: nRST low during DGNT with ramWEN=1 -> ramWEN=0, dwait=1, state IDLE asynchronously without a clock edge.
